// File: rtl/gpio_pkg.sv
// Register offsets and address-field width shared by the GPIO bank and its channels.
package gpio_pkg;
  localparam int REG_BITS = 3;

  localparam logic [REG_BITS-1:0] GPIO_OUT     = 3'd0;
  localparam logic [REG_BITS-1:0] GPIO_DIR     = 3'd1;
  localparam logic [REG_BITS-1:0] GPIO_IN      = 3'd2;
  localparam logic [REG_BITS-1:0] GPIO_SET     = 3'd3;
  localparam logic [REG_BITS-1:0] GPIO_CLR     = 3'd4;
  localparam logic [REG_BITS-1:0] GPIO_EDGE    = 3'd5;
  localparam logic [REG_BITS-1:0] GPIO_RISE_EN = 3'd6;
  localparam logic [REG_BITS-1:0] GPIO_FALL_EN = 3'd7;
endpackage

// File: rtl/gpio_chan.sv
// One GPIO channel: output latch, direction, input synchroniser, sticky edge capture.
// Edge capture (EDGE/RISE_EN/FALL_EN and the interrupt source) exists only with GPIO_EDGE_IRQ_EN.
module gpio_chan
  import gpio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [REG_BITS-1:0] regsel,
  input  logic [WIDTH-1:0]    wd,
  input  logic [WIDTH-1:0]    pin_in,
  output logic [WIDTH-1:0]    rval,
  output logic [WIDTH-1:0]    pin_out,
  output logic [WIDTH-1:0]    pin_oe,
  output logic                irq
);
  logic [WIDTH-1:0] out_lat;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_lat <= '0;
      dir     <= '0;
      sync1   <= '0;
      sync2   <= '0;
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
      if (wr) begin
        case (regsel)
          GPIO_OUT: out_lat <= wd;
          GPIO_DIR: dir     <= wd;
          GPIO_SET: out_lat <= out_lat | wd;
          GPIO_CLR: out_lat <= out_lat & ~wd;
          default:  ;
        endcase
      end
    end
  end

  assign pin_out = out_lat;
  assign pin_oe  = dir;

`ifdef GPIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_st;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] w1c;

  always_comb begin
    evt = ((sync2 & ~prev) & rise_en) | ((~sync2 & prev) & fall_en);
    w1c = (wr && regsel == GPIO_EDGE) ? wd : '0;
  end

  // A new event is OR-ed in after the clear so it survives a coincident W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev    <= '0;
      edge_st <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else begin
      prev    <= sync2;
      edge_st <= (edge_st & ~w1c) | evt;
      if (wr && regsel == GPIO_RISE_EN) rise_en <= wd;
      if (wr && regsel == GPIO_FALL_EN) fall_en <= wd;
    end
  end

  assign irq = |edge_st;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rval = '0;
    case (regsel)
      GPIO_OUT:     rval = out_lat;
      GPIO_DIR:     rval = dir;
      GPIO_IN:      rval = sync2;
`ifdef GPIO_EDGE_IRQ_EN
      GPIO_EDGE:    rval = edge_st;
      GPIO_RISE_EN: rval = rise_en;
      GPIO_FALL_EN: rval = fall_en;
`endif
      default:      rval = '0;
    endcase
  end
endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: NCH channels of WIDTH pins on the registered IO bus, address = {channel, reg}.
// Optional GPIO_EDGE_IRQ_EN adds per-pin sticky edge capture and the summed, registered irq.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter  int NCH   = 3,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(NCH) + 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic                 rd,
  input  logic [AW-1:0]        addr,
  input  logic [15:0]          wd,
  output logic [15:0]          rdata,
  input  logic [NCH*WIDTH-1:0] pin_in,
  output logic [NCH*WIDTH-1:0] pin_out,
  output logic [NCH*WIDTH-1:0] pin_oe,
  output logic                 irq
);
  localparam int CW = (AW > REG_BITS) ? AW - REG_BITS : 1;

  logic [CW-1:0]    ch;
  logic [WIDTH-1:0] rval [NCH];
  logic [NCH-1:0]   chan_irq;
  logic [WIDTH-1:0] sel;

  // With a single channel the address carries no channel field.
  generate
    if (AW > REG_BITS) begin : g_ch
      assign ch = addr[AW-1:REG_BITS];
    end else begin : g_noch
      assign ch = '0;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      gpio_chan #(.WIDTH(WIDTH)) u_chan (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr && (ch == CW'(gi))),
        .regsel  (addr[REG_BITS-1:0]),
        .wd      (wd[WIDTH-1:0]),
        .pin_in  (pin_in[gi*WIDTH +: WIDTH]),
        .rval    (rval[gi]),
        .pin_out (pin_out[gi*WIDTH +: WIDTH]),
        .pin_oe  (pin_oe[gi*WIDTH +: WIDTH]),
        .irq     (chan_irq[gi])
      );
    end
  endgenerate

  // Channel indices with no instance fall through and read as zero.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch == CW'(i)) sel = rval[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else       rdata <= rd ? 16'(sel) : 16'h0000;
  end

`ifdef GPIO_EDGE_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= |chan_irq;
  end
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank (NCH=3, WIDTH=8): table of bus ops plus edge/reset sequences.
module tb_gpio_bank;
  localparam int NCH   = 3;
  localparam int WIDTH = 8;
  localparam int AW    = $clog2(NCH) + 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 wr, rd;
  logic [AW-1:0]        addr;
  logic [15:0]          wd;
  logic [15:0]          rdata;
  logic [NCH*WIDTH-1:0] pin_in, pin_out, pin_oe;
  logic                 irq;

  gpio_bank #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wd(wd), .rdata(rdata),
    .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic        w;
    logic        r;
    logic [4:0]  a;
    logic [15:0] d;
    logic [23:0] exp_out;
    logic [23:0] exp_oe;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  // Advance one clock; sample just after the edge and retire one scoreboard entry.
  task automatic step();
    logic [15:0] e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rdata", {16'h0, rdata}, {16'h0, e});
    end
  endtask

  task automatic bus(input logic w, input logic r, input logic [4:0] a,
                     input logic [15:0] d, input logic [15:0] exp);
    wr = w; rd = r; addr = a; wd = d;
    sb.push_back(exp);
    step();
    wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    //            w     r     addr   wd      pin_out    pin_oe     rdata
    vecs[0]  = '{1'b1, 1'b0, 5'h08, 16'hA5, 24'h00A500, 24'h000000, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 5'h09, 16'hFF, 24'h00A500, 24'h00FF00, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 5'h0B, 16'h02, 24'h00A700, 24'h00FF00, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 5'h0C, 16'h80, 24'h002700, 24'h00FF00, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 5'h08, 16'h00, 24'h002700, 24'h00FF00, 16'h0027};
    vecs[5]  = '{1'b0, 1'b1, 5'h09, 16'h00, 24'h002700, 24'h00FF00, 16'h00FF};
    vecs[6]  = '{1'b0, 1'b1, 5'h0B, 16'h00, 24'h002700, 24'h00FF00, 16'h0000};
    vecs[7]  = '{1'b1, 1'b0, 5'h18, 16'hFF, 24'h002700, 24'h00FF00, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 5'h18, 16'h00, 24'h002700, 24'h00FF00, 16'h0000};
    vecs[9]  = '{1'b1, 1'b1, 5'h00, 16'h5A, 24'h00275A, 24'h00FF00, 16'h0000};
    vecs[10] = '{1'b0, 1'b1, 5'h00, 16'h00, 24'h00275A, 24'h00FF00, 16'h005A};
    vecs[11] = '{1'b0, 1'b1, 5'h12, 16'h00, 24'h00275A, 24'h00FF00, 16'h003C};
    vecs[12] = '{1'b1, 1'b0, 5'h01, 16'h0F, 24'h00275A, 24'h00FF0F, 16'h0000};
    vecs[13] = '{1'b0, 1'b1, 5'h1A, 16'h00, 24'h00275A, 24'h00FF0F, 16'h0000};
    vecs[14] = '{1'b0, 1'b1, 5'h05, 16'h00, 24'h00275A, 24'h00FF0F, 16'h0000};

    reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wd = '0;
    pin_in = 24'h3C0000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset pin_out", {8'h0, pin_out}, 32'h0);
    check("reset pin_oe",  {8'h0, pin_oe},  32'h0);
    check("reset rdata",   {16'h0, rdata},  32'h0);
    check("reset irq",     {31'h0, irq},    32'h0);
    repeat (4) step();

    for (int i = 0; i < 15; i++) begin
      bus(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].exp_rd);
      check($sformatf("vec%0d pin_out", i), {8'h0, pin_out}, {8'h0, vecs[i].exp_out});
      check($sformatf("vec%0d pin_oe", i),  {8'h0, pin_oe},  {8'h0, vecs[i].exp_oe});
    end

`ifdef GPIO_EDGE_IRQ_EN
    // Rising edge on ch0 bit 0: EDGE set 3 clocks after the change, irq one later.
    bus(1'b1, 1'b0, 5'h06, 16'h01, 16'h0000);
    bus(1'b0, 1'b1, 5'h06, 16'h00, 16'h0001);
    pin_in[0] = 1'b1;
    step();
    check("rise irq t+1", {31'h0, irq}, 32'h0);
    step();
    step();
    check("rise irq t+3", {31'h0, irq}, 32'h0);
    bus(1'b0, 1'b1, 5'h05, 16'h00, 16'h0001);
    check("rise irq t+4", {31'h0, irq}, 32'h1);
    bus(1'b1, 1'b0, 5'h05, 16'h01, 16'h0000);
    check("w1c irq same edge", {31'h0, irq}, 32'h1);
    step();
    check("w1c irq after", {31'h0, irq}, 32'h0);
    bus(1'b0, 1'b1, 5'h05, 16'h00, 16'h0000);

    // Falling edge on ch2 bit 7 coinciding with W1C of that bit.
    pin_in[23] = 1'b1;
    repeat (4) step();
    bus(1'b1, 1'b0, 5'h17, 16'h80, 16'h0000);
    pin_in[23] = 1'b0;
    repeat (5) step();
    check("fall irq", {31'h0, irq}, 32'h1);
    bus(1'b1, 1'b0, 5'h15, 16'h7F, 16'h0000);
    bus(1'b0, 1'b1, 5'h15, 16'h00, 16'h0080);
    pin_in[23] = 1'b1;
    repeat (4) step();
    pin_in[23] = 1'b0;
    step();
    step();
    bus(1'b1, 1'b0, 5'h15, 16'h80, 16'h0000);
    check("coincide irq", {31'h0, irq}, 32'h1);
    step();
    check("coincide irq+1", {31'h0, irq}, 32'h1);
    bus(1'b0, 1'b1, 5'h15, 16'h00, 16'h0080);
`else
    // Without edge capture: enables are ignored and irq never rises.
    bus(1'b1, 1'b0, 5'h06, 16'hFF, 16'h0000);
    bus(1'b1, 1'b0, 5'h07, 16'hFF, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      pin_in[7:0] = ~pin_in[7:0];
      repeat (4) step();
      check($sformatf("noedge irq %0d", k), {31'h0, irq}, 32'h0);
    end
    bus(1'b0, 1'b1, 5'h05, 16'h00, 16'h0000);
    bus(1'b0, 1'b1, 5'h06, 16'h00, 16'h0000);
    bus(1'b0, 1'b1, 5'h07, 16'h00, 16'h0000);
`endif

    // Asynchronous reset mid-run clears outputs without waiting for a clock edge.
    bus(1'b0, 1'b1, 5'h08, 16'h00, 16'h0027);
    reset = 1'b1;
    #1;
    check("midreset pin_out", {8'h0, pin_out}, 32'h0);
    check("midreset pin_oe",  {8'h0, pin_oe},  32'h0);
    check("midreset rdata",   {16'h0, rdata},  32'h0);
    check("midreset irq",     {31'h0, irq},    32'h0);
    #10 reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
